// File: rtl/mod6_seq_checker_if.sv
// Monitor bus between the mod-6 counter side (master) and the sequence checker (slave).
// The master drives the sampled count and controls. The slave returns lock and error status.
interface mod6_seq_checker_if #(
    parameter int CNT_W  = 3,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
);
    logic              en;
    logic [CNT_W-1:0]  q_in;
    logic              up_reset;
    logic              clr_stats;
    logic              locked;
    logic              wrap_pulse;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic              err_sticky;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output en, q_in, up_reset, clr_stats,
        input  locked, wrap_pulse, err_pulse, err_code, err_sticky, wrap_count, err_count
    );

    modport slave (
        input  en, q_in, up_reset, clr_stats,
        output locked, wrap_pulse, err_pulse, err_code, err_sticky, wrap_count, err_count
    );
endinterface

// File: rtl/mod6_seq_checker.sv
// Sequence monitor for a mod-MOD counter. It locks onto 0,1,..,MOD-1,0 and classifies
// range, stall and skip errors. It also keeps saturating wrap and error statistics.
module mod6_seq_checker #(
    parameter int MOD         = 6,
    parameter int CNT_W       = 3,
    parameter int LOCK_CYCLES = 2,
    parameter int WRAP_W      = 8,
    parameter int ERR_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    mod6_seq_checker_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SKIP  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_STALL = 2'b11;

    localparam int               GOOD_W   = 3;
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(MOD - 1);
    localparam logic [CNT_W:0]    MOD_EXT  = (CNT_W + 1)'(MOD);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  prev, prev_nxt;
    logic [GOOD_W-1:0] good_cnt, good_nxt, good_inc;
    logic              wrap_evt, err_evt;
    logic [1:0]        err_cls;

    logic              wrap_pulse, err_pulse, err_sticky;
    logic [1:0]        err_code;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    logic in_range, step_ok;

    // The extra MSB keeps the range test correct even when MOD equals 2**CNT_W.
    assign in_range = ({1'b0, bus.q_in} < MOD_EXT);
    assign step_ok  = in_range && ((prev == LAST) ? (bus.q_in == '0)
                                                  : (bus.q_in == prev + CNT_W'(1)));
    assign good_inc = good_cnt + GOOD_W'(1);

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        good_nxt  = good_cnt;
        wrap_evt  = 1'b0;
        err_evt   = 1'b0;
        err_cls   = ERR_NONE;

        if (!in_range)                err_cls = ERR_RANGE;
        else if (bus.q_in == prev)    err_cls = ERR_STALL;
        else                          err_cls = ERR_SKIP;

        if (bus.en) begin
            if (bus.up_reset) begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end else begin
                if (in_range) prev_nxt = bus.q_in;
                case (state)
                    IDLE: begin
                        if (in_range) begin
                            good_nxt  = '0;
                            state_nxt = SYNC;
                        end
                    end
                    SYNC: begin
                        if (!in_range) begin
                            state_nxt = IDLE;
                        end else if (step_ok) begin
                            good_nxt = good_inc;
                            if (good_inc == LOCK_TGT) state_nxt = LOCKED;
                        end else begin
                            good_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (step_ok) begin
                            wrap_evt = (prev == LAST);
                        end else begin
                            err_evt   = 1'b1;
                            good_nxt  = '0;
                            state_nxt = in_range ? SYNC : IDLE;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            good_cnt   <= '0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
            err_sticky <= 1'b0;
            wrap_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            good_cnt   <= good_nxt;
            wrap_pulse <= wrap_evt;
            err_pulse  <= err_evt;

            // Statistics clear acts whether or not en is high. It overrides a same-cycle event.
            if (bus.clr_stats) begin
                wrap_count <= '0;
                err_count  <= '0;
                err_sticky <= 1'b0;
                err_code   <= ERR_NONE;
            end else begin
                if (wrap_evt && (wrap_count != '1))
                    wrap_count <= wrap_count + WRAP_W'(1);
                if (err_evt) begin
                    err_code   <= err_cls;
                    err_sticky <= 1'b1;
                    if (err_count != '1)
                        err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

    assign bus.locked     = (state == LOCKED);
    assign bus.wrap_pulse = wrap_pulse;
    assign bus.err_pulse  = err_pulse;
    assign bus.err_code   = err_code;
    assign bus.err_sticky = err_sticky;
    assign bus.wrap_count = wrap_count;
    assign bus.err_count  = err_count;

endmodule
